// File: rtl/systolic_conv_ctrl_if.sv
// Byte stream from the convolution sequencer to the UART transmitter.
// A byte moves on any rising edge where tx_valid and tx_ready are both high.
interface systolic_conv_ctrl_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/systolic_conv_ctrl.sv
// Sequencer for the 2x2 weight-stationary systolic convolution: clear, load, step the MAC
// array, then stream a framed byte sequence (header + hi/lo per psum) over valid/ready.
module systolic_conv_ctrl #(
    parameter int         DATA_WIDTH   = 8,
    parameter int         OUTPUT_WIDTH = 16,
    parameter int         N_OUT        = 4,
    parameter int         K_STEPS      = 4,
    parameter int         PIPE_LAT     = 2,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pe_clr,
    output logic                    pe_load_w,
    output logic                    pe_en,
    output logic [1:0]              k_idx,
    output logic [1:0]              psum_sel,
    input  logic [OUTPUT_WIDTH-1:0] psum_in,
    systolic_conv_ctrl_if.master    tx,
    output logic [3:0]              dbg_state
);

    if (OUTPUT_WIDTH != 16 || DATA_WIDTH > OUTPUT_WIDTH) begin : g_bad_width
        $error("systolic_conv_ctrl: OUTPUT_WIDTH must be 16 and hold a DATA_WIDTH product");
    end

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CLEAR   = 4'd1,
        S_LOADW   = 4'd2,
        S_COMPUTE = 4'd3,
        S_DRAIN   = 4'd4,
        S_HDR     = 4'd5,
        S_FETCH   = 4'd6,
        S_TX_HI   = 4'd7,
        S_TX_LO   = 4'd8,
        S_FIN     = 4'd9
    } state_t;

    localparam logic [1:0] K_LAST = 2'(K_STEPS - 1);
    localparam logic [1:0] J_LAST = 2'(N_OUT - 1);
    localparam logic [3:0] D_LAST = 4'(PIPE_LAT - 1);

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_pe_clr;
    logic        r_pe_load_w;
    logic        r_pe_en;
    logic [1:0]  r_k_idx;
    logic [1:0]  r_psum_sel;
    logic [1:0]  r_j;
    logic [3:0]  r_drain;
    logic [15:0] r_word;
    logic        r_tx_valid;
    logic [7:0]  w_tx_data;
    logic        w_hs;

    assign w_hs = r_tx_valid && tx.tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pe_clr    <= 1'b0;
            r_pe_load_w <= 1'b0;
            r_pe_en     <= 1'b0;
            r_k_idx     <= 2'd0;
            r_psum_sel  <= 2'd0;
            r_j         <= 2'd0;
            r_drain     <= 4'd0;
            r_word      <= 16'd0;
            r_tx_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_CLEAR;
                        r_busy   <= 1'b1;
                        r_pe_clr <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state     <= S_LOADW;
                    r_pe_clr    <= 1'b0;
                    r_pe_load_w <= 1'b1;
                end
                S_LOADW: begin
                    r_state     <= S_COMPUTE;
                    r_pe_load_w <= 1'b0;
                    r_pe_en     <= 1'b1;
                    r_k_idx     <= 2'd0;
                end
                S_COMPUTE: begin
                    if (r_k_idx == K_LAST) begin
                        r_state <= S_DRAIN;
                        r_pe_en <= 1'b0;
                        r_k_idx <= 2'd0;
                        r_drain <= 4'd0;
                    end else begin
                        r_k_idx <= r_k_idx + 2'd1;
                    end
                end
                S_DRAIN: begin
                    // valid is raised on the way out so the header is offered on entry to HDR
                    if (r_drain == D_LAST) begin
                        r_state    <= S_HDR;
                        r_tx_valid <= 1'b1;
                        r_j        <= 2'd0;
                    end else begin
                        r_drain <= r_drain + 4'd1;
                    end
                end
                S_HDR: begin
                    if (w_hs) begin
                        r_state    <= S_FETCH;
                        r_tx_valid <= 1'b0;
                        r_psum_sel <= r_j;
                    end
                end
                S_FETCH: begin
                    r_state    <= S_TX_HI;
                    r_word     <= psum_in;
                    r_tx_valid <= 1'b1;
                end
                S_TX_HI: begin
                    if (w_hs) begin
                        r_state <= S_TX_LO;
                    end
                end
                S_TX_LO: begin
                    if (w_hs) begin
                        r_tx_valid <= 1'b0;
                        if (r_j == J_LAST) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_FETCH;
                            r_j        <= r_j + 2'd1;
                            r_psum_sel <= r_j + 2'd1;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The byte on the bus is a pure decode of registered state, so it cannot move while stalled.
    always_comb begin
        w_tx_data = 8'd0;
        case (r_state)
            S_HDR:   w_tx_data = HEADER;
            S_TX_HI: w_tx_data = r_word[15:8];
            S_TX_LO: w_tx_data = r_word[7:0];
            default: w_tx_data = 8'd0;
        endcase
    end

    assign tx.tx_data  = w_tx_data;
    assign tx.tx_valid = r_tx_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pe_clr      = r_pe_clr;
    assign pe_load_w   = r_pe_load_w;
    assign pe_en       = r_pe_en;
    assign k_idx       = r_k_idx;
    assign psum_sel    = r_psum_sel;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_systolic_conv_ctrl.sv
// Bench for systolic_conv_ctrl: frame bytes and cycle timing checked against a schedule model.
module tb_systolic_conv_ctrl;

  localparam int RP = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        pe_clr;
  logic        pe_load_w;
  logic        pe_en;
  logic [1:0]  k_idx;
  logic [1:0]  psum_sel;
  logic [15:0] psum_in;
  logic [3:0]  dbg_state;

  logic [15:0] psum_mem [4];
  logic        ready_pat [RP];
  logic [7:0]  exp_q [$];

  int total = 0;
  int bad = 0;

  systolic_conv_ctrl_if tx_if ();

  systolic_conv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pe_clr    (pe_clr),
    .pe_load_w (pe_load_w),
    .pe_en     (pe_en),
    .k_idx     (k_idx),
    .psum_sel  (psum_sel),
    .psum_in   (psum_in),
    .tx        (tx_if),
    .dbg_state (dbg_state)
  );

  // clock / datapath stand-in
  always #5 clk = ~clk;
  assign psum_in = psum_mem[psum_sel];

  task automatic fill_ready(input bit random_mode);
    for (int i = 0; i < RP; i++) begin
      if (random_mode && i < 300) ready_pat[i] = ($urandom_range(0, 2) != 0);
      else ready_pat[i] = 1'b1;
    end
  endtask

  task automatic set_psums(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    psum_mem[0] = a;
    psum_mem[1] = b;
    psum_mem[2] = c;
    psum_mem[3] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    tx_if.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({busy, done, pe_clr, pe_load_w, pe_en, tx_if.tx_valid, k_idx, psum_sel, tx_if.tx_data} !== 17'd0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: outputs=%h want 0", i,
                 {busy, done, pe_clr, pe_load_w, pe_en, tx_if.tx_valid, k_idx, psum_sel, tx_if.tx_data});
      end
    end
  endtask

  // One frame started from a negedge; expected schedule derived from ready_pat and the frame rules.
  task automatic test_frame(input string tag, input bit hold, input bit stall3);
    int vs [9];
    int xf [9];
    logic [7:0] eb [9];
    int t;
    int done_c;
    logic exp_v;
    logic [7:0] exp_d;
    logic [2:0] exp_pe;
    logic [7:0] got;

    eb[0] = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      eb[1 + 2 * i] = 8'(psum_mem[i] / 16'd256);
      eb[2 + 2 * i] = 8'(psum_mem[i] % 16'd256);
    end
    t = 9;
    for (int b = 0; b < 9; b++) begin
      vs[b] = t;
      if (stall3 && (b % 3 == 2)) begin
        for (int k = 0; k < 5; k++) ready_pat[t + k] = 1'b0;
      end
      while (t < RP - 1 && !ready_pat[t]) t++;
      xf[b] = t;
      t = (b % 2 == 0) ? t + 2 : t + 1;
    end
    done_c = xf[8] + 1;
    exp_q.delete();
    for (int b = 0; b < 9; b++) exp_q.push_back(eb[b]);

    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int n = 1; n <= done_c + 1; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      tx_if.tx_ready = ready_pat[n];
      @(negedge clk);

      exp_pe = {n == 1, n == 2, n >= 3 && n <= 6};
      total++;
      if ({pe_clr, pe_load_w, pe_en} !== exp_pe) begin
        bad++;
        $display("FAIL %s pe cycle %0d: got %b want %b", tag, n, {pe_clr, pe_load_w, pe_en}, exp_pe);
      end
      if (n >= 3 && n <= 6) begin
        total++;
        if (k_idx !== 2'(n - 3)) begin
          bad++;
          $display("FAIL %s k_idx cycle %0d: got %0d want %0d", tag, n, k_idx, n - 3);
        end
      end

      exp_v = 1'b0;
      exp_d = 8'd0;
      for (int b = 0; b < 9; b++) begin
        if (n >= vs[b] && n <= xf[b]) begin
          exp_v = 1'b1;
          exp_d = eb[b];
        end
      end
      total++;
      if (tx_if.tx_valid !== exp_v) begin
        bad++;
        $display("FAIL %s tx_valid cycle %0d: got %b want %b", tag, n, tx_if.tx_valid, exp_v);
      end
      if (exp_v) begin
        total++;
        if (tx_if.tx_data !== exp_d) begin
          bad++;
          $display("FAIL %s tx_data cycle %0d: got %h want %h", tag, n, tx_if.tx_data, exp_d);
        end
      end

      if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) begin
        got = tx_if.tx_data;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s extra_byte cycle %0d: got %h want none", tag, n, got);
        end else if (got !== exp_q[0]) begin
          bad++;
          $display("FAIL %s byte cycle %0d: got %h want %h", tag, n, got, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end

      total++;
      if (done !== (n == done_c)) begin
        bad++;
        $display("FAIL %s done cycle %0d: got %b want %b", tag, n, done, n == done_c);
      end
      total++;
      if (busy !== (n <= done_c)) begin
        bad++;
        $display("FAIL %s busy cycle %0d: got %b want %b", tag, n, busy, n <= done_c);
      end
    end

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s missing_bytes: got %0d left want 0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    fill_ready(1'b0);
    tx_if.tx_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk);
      #1;
    end
    // cycle 15 is TX_LO of r1 with ready high
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 8'(psum_mem[1] % 16'd256)) begin
      bad++;
      $display("FAIL rst_mid pre: valid=%b data=%h want 1 %h", tx_if.tx_valid, tx_if.tx_data,
               8'(psum_mem[1] % 16'd256));
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 16; n <= 35; n++) begin
      if (n > 16) @(posedge clk);
      @(negedge clk);
      total++;
      if ({busy, done, tx_if.tx_valid} !== 3'b000) begin
        bad++;
        $display("FAIL rst_mid post cycle %0d: busy/done/valid=%b want 000", n, {busy, done, tx_if.tx_valid});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    tx_if.tx_ready = 1'b0;
    set_psums(16'd0, 16'd0, 16'd0, 16'd0);
    fill_ready(1'b0);

    test_reset();

    set_psums(16'd6, 16'd0, 16'd0, 16'd6);
    fill_ready(1'b0);
    test_frame("nominal", 1'b0, 1'b0);

    set_psums(16'hFFFF, 16'h8001, 16'h0100, 16'h00FF);
    fill_ready(1'b0);
    test_frame("large", 1'b0, 1'b0);

    set_psums(16'd6, 16'd0, 16'd0, 16'd6);
    fill_ready(1'b0);
    test_frame("backpressure", 1'b0, 1'b1);

    set_psums(16'h1234, 16'hABCD, 16'h0F0F, 16'h7E81);
    fill_ready(1'b0);
    test_frame("b2b_first", 1'b1, 1'b0);
    fill_ready(1'b0);
    test_frame("b2b_second", 1'b1, 1'b0);
    start = 1'b0;

    set_psums(16'h0102, 16'h0304, 16'h0506, 16'h0708);
    test_reset_mid();
    fill_ready(1'b0);
    test_frame("after_rst", 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      set_psums(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      fill_ready(1'b1);
      test_frame("random", 1'b0, (r % 2) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_conv_ctrl.md
# systolic_conv_ctrl

Sequencer for the 2x2 weight-stationary systolic convolution datapath. On a start command it clears partial sums, loads weights and steps the MAC array through the im2col columns. It then reads back each 16-bit result and streams a framed byte sequence to the 8N1 UART transmitter over a valid/ready handshake. It sits between the top-level trigger/LED logic and the MAC array and UART.

## Interface
- DATA_WIDTH, 8, activation/weight width
- OUTPUT_WIDTH, 16, psum width; must be 16 (two bytes per result)
- N_OUT, 4, number of psum results read back
- K_STEPS, 4, MAC steps (im2col columns) per convolution
- PIPE_LAT, 2, drain cycles after last MAC step before psums are valid
- HEADER, 8'hA5, frame start byte

- clk  in  1  system clock (12 MHz)
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one convolution; sampled only in IDLE
- busy  out  1  high while a convolution or transmission is in progress
- done  out  1  one-cycle pulse after the last byte is accepted
- pe_clr  out  1  clear all psums (one cycle)
- pe_load_w  out  1  load kernel into weight registers (one cycle)
- pe_en  out  1  perform one MAC step
- k_idx  out  2  im2col column index fed during pe_en
- psum_sel  out  2  psum read-port select
- psum_in  in  OUTPUT_WIDTH  selected psum (combinational from datapath)
- tx_data  out  8  byte to UART
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART can accept byte

## Operation
- States: IDLE, CLEAR, LOADW, COMPUTE, DRAIN, HDR, FETCH, TX_HI, TX_LO, FIN.
- IDLE -> CLEAR on start. CLEAR -> LOADW -> COMPUTE, one cycle each.
- COMPUTE lasts K_STEPS cycles. pe_en=1 and k_idx counts 0..K_STEPS-1, then goes to DRAIN.
- DRAIN lasts PIPE_LAT cycles with pe_en=0, then goes to HDR.
- HDR: tx_data=HEADER, tx_valid=1 until the handshake, then FETCH with j=0.
- FETCH: psum_sel=j for one cycle; psum_in is latched into a 16-bit word register at the end of the cycle; then TX_HI.
- TX_HI sends word[15:8]. TX_LO sends word[7:0]. Each holds tx_valid until the handshake.
- After TX_LO, if j<N_OUT-1 the FSM increments j and goes to FETCH; otherwise it goes to FIN.
- FIN: done=1 for one cycle, then IDLE.
- Handshake: a transfer occurs on any rising edge with tx_valid && tx_ready. tx_data and tx_valid must stay stable while tx_ready is low. tx_valid never drops without a transfer, except on rst.
- Frame is 1 + 2*N_OUT bytes (9 by default): A5, r0_hi, r0_lo, ..., r3_hi, r3_lo.
- busy=1 in every state except IDLE.
- start outside IDLE is ignored. A start in the same cycle as FIN is ignored; start must be reasserted in IDLE.
- Outputs pe_clr, pe_load_w and pe_en are mutually exclusive and are only asserted in their own states.

## Timing
- Reset values: state IDLE; busy, done, pe_clr, pe_load_w, pe_en, tx_valid = 0; k_idx, psum_sel, tx_data = 0; j and word register = 0.
- Cycle numbering: start is sampled high at edge 0; cycle n is the cycle after edge n.
- pe_clr is high in cycle 1 and pe_load_w in cycle 2.
- pe_en is high in cycles 3..2+K_STEPS, with k_idx=0..3 in cycles 3..6.
- DRAIN occupies cycles 7..8 and tx_valid rises in cycle 9.
- With tx_ready tied high: header in cycle 9; each result takes 3 cycles (FETCH, HI, LO) in cycles 10..21; done in cycle 22; IDLE in cycle 23.
- Each cycle tx_ready is low during a TX state adds one cycle of stall. No byte is duplicated or dropped.
- rst at any point returns to IDLE on the next edge. tx_valid and busy are low in the following cycle and no done pulse is issued.
- Counters k_idx and j never wrap mid-frame. They reset to 0 on entry to COMPUTE and HDR respectively.

## Test plan
- Reset then idle: rst for 2 cycles, start=0 for 20 cycles -> all outputs 0, no pe_* or tx_valid activity.
- Nominal run, tx_ready=1, datapath psums {1,2,4,5}+{0,0,0,1} model giving r={6,0,0,6}: start pulse -> pe_clr@1, pe_load_w@2, pe_en@3..6 with k_idx 0..3, bytes A5,00,06,00,00,00,00,00,06, done@22.
- Backpressure: tx_ready low for 5 cycles on every third byte -> identical byte sequence, tx_data stable while stalled, done delayed by total stall cycles.
- start held high continuously -> back-to-back frames separated by exactly one IDLE cycle after each done; start during busy causes no restart.
- Reset mid-transmission: rst asserted during TX_LO of r1 -> tx_valid=0 and busy=0 the next cycle, no done pulse; a new start produces a complete 9-byte frame.
- Large values: psums {0xFFFF, 0x8001, 0x0100, 0x00FF} -> bytes A5,FF,FF,80,01,01,00,00,FF.
